// File: rtl/bola_nave_if.sv
// bola_nave_if: control/status bundle between the game logic and the player-shot controller.
//   reiniciarJogo, pausa, disparo, nave_x, nave_y, acerto : game side -> controller
//   bola_nave_x, bola_nave_y, ativa, acertos              : controller -> game side
//   master = game/ship side, slave = bola_nave_ctrl
interface bola_nave_if;
    logic       reiniciarJogo;
    logic       pausa;
    logic       disparo;
    logic [9:0] nave_x;
    logic [9:0] nave_y;
    logic       acerto;
    logic [9:0] bola_nave_x;
    logic [9:0] bola_nave_y;
    logic       ativa;
    logic [7:0] acertos;
    modport master (
        output reiniciarJogo, pausa, disparo, nave_x, nave_y, acerto,
        input  bola_nave_x, bola_nave_y, ativa, acertos
    );
    modport slave (
        input  reiniciarJogo, pausa, disparo, nave_x, nave_y, acerto,
        output bola_nave_x, bola_nave_y, ativa, acertos
    );
endinterface

// File: rtl/bola_nave_ctrl.sv
// bola_nave_ctrl: player shot launcher/mover with hit counter and post-shot cooldown.
//   CLOCK_50 : clock, everything on posedge
//   reset    : synchronous active-high clear
//   bus      : bola_nave_if.slave (restart, pause, fire, ship position, hit in; shot position,
//              ativa, acertos out; all outputs registered)
//   Optional BOLA_AUTOFIRE_EN: a held fire level launches from IDLE instead of a rising edge.
module bola_nave_ctrl #(
    parameter int DIV_MV         = 500000,
    parameter int VEL            = 4,
    parameter int OFFSET_X       = 16,
    parameter int COOLDOWN_TICKS = 8
) (
    input logic        CLOCK_50,
    input logic        reset,
    bola_nave_if.slave bus
);
    localparam int CW = $clog2(DIV_MV);
    localparam int DW = $clog2(COOLDOWN_TICKS + 1);
    typedef enum logic [1:0] {IDLE, VOANDO, RECARGA} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] cd_q;
    logic [9:0]    x_q, y_q;
    logic [7:0]    acertos_q;
    logic          ativa_q, disp_q;
    logic          tick, mv, fire;
    logic [10:0]   sx;
    always_comb begin
        tick = cnt_q == CW'(DIV_MV - 1);
        mv   = tick & ~bus.pausa;
        // 11-bit sum so a ship near x=1023 still clamps instead of wrapping
        sx   = {1'b0, bus.nave_x} + 11'(OFFSET_X);
`ifdef BOLA_AUTOFIRE_EN
        fire = bus.disparo;
`else
        fire = bus.disparo & ~disp_q;
`endif
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset | bus.reiniciarJogo) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cd_q      <= '0;
            x_q       <= 10'd0;
            y_q       <= 10'd1023;
            ativa_q   <= 1'b0;
            acertos_q <= 8'd0;
            disp_q    <= 1'b0;
        end else begin
            cnt_q  <= tick ? '0 : cnt_q + CW'(1);
            disp_q <= bus.disparo;
            case (state_q)
                IDLE: if (fire & ~bus.pausa) begin
                    state_q <= VOANDO;
                    x_q     <= sx > 11'd639 ? 10'd639 : sx[9:0];
                    y_q     <= bus.nave_y;
                    ativa_q <= 1'b1;
                end
                VOANDO: if (bus.acerto | (mv & (y_q < 10'(VEL)))) begin
                    // a hit on the same cycle as the top exit is still counted
                    state_q <= RECARGA;
                    x_q     <= 10'd0;
                    y_q     <= 10'd1023;
                    ativa_q <= 1'b0;
                    cd_q    <= DW'(COOLDOWN_TICKS);
                    if (bus.acerto && acertos_q != 8'hFF) acertos_q <= acertos_q + 8'd1;
                end else if (mv) begin
                    y_q <= y_q - 10'(VEL);
                end
                RECARGA: if (mv) begin
                    cd_q <= cd_q - DW'(1);
                    if (cd_q == DW'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.bola_nave_x = x_q;
    assign bus.bola_nave_y = y_q;
    assign bus.ativa       = ativa_q;
    assign bus.acertos     = acertos_q;
endmodule

// File: tb/tb_bola_nave_ctrl.sv
// tb_bola_nave_ctrl: directed bench for bola_nave_ctrl with DIV_MV=4, VEL=4, OFFSET_X=16, COOLDOWN_TICKS=2.
module tb_bola_nave_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   ph = 0;
    bola_nave_if bus();
    bola_nave_ctrl #(.DIV_MV(4), .VEL(4), .OFFSET_X(16), .COOLDOWN_TICKS(2)) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // phase of the free-running movement divider; tick edge is the posedge where ph==3
    always @(posedge clk) ph <= (reset | bus.reiniciarJogo) ? 0 : (ph == 3 ? 0 : ph + 1);
    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        while (ph != 3) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic fire_pulse();
        bus.disparo = 1'b1;
        cyc(1);
        bus.disparo = 1'b0;
    endtask

    task automatic hit_pulse();
        bus.acerto = 1'b1;
        cyc(1);
        bus.acerto = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.reiniciarJogo = 1'b0;
        bus.pausa = 1'b0;
        bus.disparo = 1'b0;
        bus.acerto = 1'b0;
        bus.nave_x = 10'd100;
        bus.nave_y = 10'd400;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.ativa !== 1'b0) begin errors++; $display("FAIL rst_ativa got=%0d exp=0", bus.ativa); end
        checks++; if (bus.bola_nave_x !== 10'd0) begin errors++; $display("FAIL rst_x got=%0d exp=0", bus.bola_nave_x); end
        checks++; if (bus.bola_nave_y !== 10'd1023) begin errors++; $display("FAIL rst_y got=%0d exp=1023", bus.bola_nave_y); end
        checks++; if (bus.acertos !== 8'd0) begin errors++; $display("FAIL rst_acertos got=%0d exp=0", bus.acertos); end
    endtask

    task automatic test_flight();
        do_reset();
        fire_pulse();
        checks++; if (bus.ativa !== 1'b1) begin errors++; $display("FAIL fly_ativa got=%0d exp=1", bus.ativa); end
        checks++; if (bus.bola_nave_x !== 10'd116) begin errors++; $display("FAIL fly_x got=%0d exp=116", bus.bola_nave_x); end
        checks++; if (bus.bola_nave_y !== 10'd400) begin errors++; $display("FAIL fly_y0 got=%0d exp=400", bus.bola_nave_y); end
        repeat (3) wait_tick();
        checks++; if (bus.bola_nave_y !== 10'd388) begin errors++; $display("FAIL fly_y3 got=%0d exp=388", bus.bola_nave_y); end
    endtask

    task automatic test_top_exit();
        do_reset();
        bus.nave_y = 10'd8;
        fire_pulse();
        checks++; if (bus.bola_nave_y !== 10'd8) begin errors++; $display("FAIL top_y8 got=%0d exp=8", bus.bola_nave_y); end
        wait_tick();
        checks++; if (bus.bola_nave_y !== 10'd4) begin errors++; $display("FAIL top_y4 got=%0d exp=4", bus.bola_nave_y); end
        wait_tick();
        checks++; if (bus.bola_nave_y !== 10'd0) begin errors++; $display("FAIL top_y0 got=%0d exp=0", bus.bola_nave_y); end
        wait_tick();
        checks++; if (bus.ativa !== 1'b0) begin errors++; $display("FAIL top_ativa got=%0d exp=0", bus.ativa); end
        checks++; if (bus.bola_nave_y !== 10'd1023) begin errors++; $display("FAIL top_park got=%0d exp=1023", bus.bola_nave_y); end
        checks++; if (bus.acertos !== 8'd0) begin errors++; $display("FAIL top_acertos got=%0d exp=0", bus.acertos); end
        wait_tick();
        fire_pulse();
        checks++; if (bus.ativa !== 1'b0) begin errors++; $display("FAIL cd_drop got=%0d exp=0", bus.ativa); end
        wait_tick();
        fire_pulse();
        checks++; if (bus.ativa !== 1'b1) begin errors++; $display("FAIL cd_relaunch got=%0d exp=1", bus.ativa); end
    endtask

    task automatic test_hit();
        do_reset();
        fire_pulse();
        cyc(2);
        hit_pulse();
        checks++; if (bus.ativa !== 1'b0) begin errors++; $display("FAIL hit_ativa got=%0d exp=0", bus.ativa); end
        checks++; if (bus.acertos !== 8'd1) begin errors++; $display("FAIL hit_count got=%0d exp=1", bus.acertos); end
        checks++; if (bus.bola_nave_x !== 10'd0) begin errors++; $display("FAIL hit_x got=%0d exp=0", bus.bola_nave_x); end
        hit_pulse();
        checks++; if (bus.acertos !== 8'd1) begin errors++; $display("FAIL hit_recarga got=%0d exp=1", bus.acertos); end
        wait_tick();
        wait_tick();
        hit_pulse();
        checks++; if (bus.acertos !== 8'd1) begin errors++; $display("FAIL hit_idle got=%0d exp=1", bus.acertos); end
    endtask

    task automatic test_pause();
        do_reset();
        fire_pulse();
        bus.pausa = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.disparo = i[0];
            cyc(1);
        end
        bus.disparo = 1'b0;
        checks++; if (bus.bola_nave_y !== 10'd400) begin errors++; $display("FAIL pause_y got=%0d exp=400", bus.bola_nave_y); end
        checks++; if (bus.bola_nave_x !== 10'd116) begin errors++; $display("FAIL pause_x got=%0d exp=116", bus.bola_nave_x); end
        hit_pulse();
        checks++; if (bus.ativa !== 1'b0) begin errors++; $display("FAIL pause_hit_ativa got=%0d exp=0", bus.ativa); end
        checks++; if (bus.acertos !== 8'd1) begin errors++; $display("FAIL pause_hit_count got=%0d exp=1", bus.acertos); end
        bus.pausa = 1'b0;
    endtask

    task automatic one_hit();
        fire_pulse();
        hit_pulse();
        wait_tick();
        wait_tick();
    endtask

    task automatic test_clamp_sat();
        do_reset();
        bus.nave_x = 10'd630;
        bus.nave_y = 10'd0;
        fire_pulse();
        checks++; if (bus.bola_nave_x !== 10'd639) begin errors++; $display("FAIL clamp_630 got=%0d exp=639", bus.bola_nave_x); end
        while (ph != 3) cyc(1);
        hit_pulse();
        checks++; if (bus.acertos !== 8'd1) begin errors++; $display("FAIL hit_exit_count got=%0d exp=1", bus.acertos); end
        checks++; if (bus.ativa !== 1'b0) begin errors++; $display("FAIL hit_exit_ativa got=%0d exp=0", bus.ativa); end
        wait_tick();
        wait_tick();
        bus.nave_x = 10'd1023;
        bus.nave_y = 10'd400;
        fire_pulse();
        checks++; if (bus.bola_nave_x !== 10'd639) begin errors++; $display("FAIL clamp_1023 got=%0d exp=639", bus.bola_nave_x); end
        hit_pulse();
        wait_tick();
        wait_tick();
        repeat (252) one_hit();
        checks++; if (bus.acertos !== 8'd254) begin errors++; $display("FAIL sat_254 got=%0d exp=254", bus.acertos); end
        one_hit();
        checks++; if (bus.acertos !== 8'd255) begin errors++; $display("FAIL sat_255 got=%0d exp=255", bus.acertos); end
        one_hit();
        checks++; if (bus.acertos !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d exp=255", bus.acertos); end
    endtask

    task automatic test_restart();
        do_reset();
        fire_pulse();
        hit_pulse();
        wait_tick();
        wait_tick();
        fire_pulse();
        cyc(2);
        bus.reiniciarJogo = 1'b1;
        cyc(1);
        bus.reiniciarJogo = 1'b0;
        checks++; if (bus.ativa !== 1'b0) begin errors++; $display("FAIL rj_ativa got=%0d exp=0", bus.ativa); end
        checks++; if (bus.bola_nave_y !== 10'd1023) begin errors++; $display("FAIL rj_y got=%0d exp=1023", bus.bola_nave_y); end
        checks++; if (bus.bola_nave_x !== 10'd0) begin errors++; $display("FAIL rj_x got=%0d exp=0", bus.bola_nave_x); end
        checks++; if (bus.acertos !== 8'd0) begin errors++; $display("FAIL rj_acertos got=%0d exp=0", bus.acertos); end
        fire_pulse();
        checks++; if (bus.ativa !== 1'b1) begin errors++; $display("FAIL rj_idle_fire got=%0d exp=1", bus.ativa); end
    endtask

    task automatic test_held();
        int   n = 0;
        logic prev = 1'b0;
        do_reset();
        bus.nave_y = 10'd8;
        bus.disparo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (bus.ativa && !prev) n++;
            prev = bus.ativa;
        end
        bus.disparo = 1'b0;
`ifdef BOLA_AUTOFIRE_EN
        checks++; if (n < 4) begin errors++; $display("FAIL held_autofire launches=%0d exp>=4", n); end
`else
        checks++; if (n != 1) begin errors++; $display("FAIL held_single launches=%0d exp=1", n); end
`endif
    endtask

    initial begin
        test_reset();
        test_flight();
        test_top_exit();
        test_hit();
        test_pause();
        test_clamp_sat();
        test_restart();
        test_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
